// File: rtl/all_pkgs.sv
// Shared types for the decode-stage interlock: FSM state encoding and register constants.
package all_pkgs;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Pending-write mask for the 32 integer registers. It has one set port and one clear port,
// plus two RAW read ports and one WAW read port. Reads see only the registered mask.
module reg_scoreboard
  import all_pkgs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] waw_rd,
  output logic       rs1_pend,
  output logic       rs2_pend,
  output logic       waw_pend
);

  logic [31:0] pending_q;
  logic [31:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_rd] = 1'b0;
    if (set_en) pending_d[set_rd] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign rs1_pend = pending_q[rs1];
  assign rs2_pend = pending_q[rs2];
  assign waw_pend = pending_q[waw_rd];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: detects RAW/WAW hazards and drives the stall, bubble and flush controls.
// Defining HAZARD_FWD_EN replaces the scoreboard with a single load-use tracker.
module hazard_ctrl
  import all_pkgs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic             issue,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic hazard;
  logic rd_nonzero;

  assign rd_nonzero = (id_rd != REG_ZERO);

`ifdef HAZARD_FWD_EN
  logic       ld_valid_q, ld_valid_d;
  logic [4:0] ld_rd_q, ld_rd_d;
  logic       unused_wb;

  // Only a load that actually issues can create a load-use hazard next cycle.
  always_comb begin
    ld_valid_d = issue & id_is_load & id_wr_en & rd_nonzero;
    ld_rd_d    = ld_valid_d ? id_rd : REG_ZERO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_valid_q <= 1'b0;
      ld_rd_q    <= REG_ZERO;
    end else begin
      ld_valid_q <= ld_valid_d;
      ld_rd_q    <= ld_rd_d;
    end
  end

  assign hazard = id_valid & ld_valid_q &
                  ((id_use_rs1 & (id_rs1 == ld_rd_q)) |
                   (id_use_rs2 & (id_rs2 == ld_rd_q)));
  assign unused_wb = ^{wb_en, wb_rd};
`else
  logic rs1_pend, rs2_pend, waw_pend;
  logic unused_load;

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue & id_wr_en & rd_nonzero),
    .set_rd   (id_rd),
    .clr_en   (wb_en & (wb_rd != REG_ZERO)),
    .clr_rd   (wb_rd),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .waw_rd   (id_rd),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .waw_pend (waw_pend)
  );

  assign hazard = id_valid &
                  ((id_use_rs1 & (id_rs1 != REG_ZERO) & rs1_pend) |
                   (id_use_rs2 & (id_rs2 != REG_ZERO) & rs2_pend) |
                   (id_wr_en & rd_nonzero & waw_pend));
  assign unused_load = id_is_load;
`endif

  hz_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (ex_branch_taken) state_d = FLUSH;
    else if (hazard)     state_d = STALL;
  end

  // A taken branch wins over a hazard: the ID instruction is discarded, not held.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    flush_ifid = 1'b0;
    issue      = 1'b0;
    if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      bubble_ex  = 1'b1;
    end else if (hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  assign state = state_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard && !ex_branch_taken && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (ex_branch_taken && (flush_cnt_q != '1))            flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
